// File: rtl/pool_pkg.sv
// Shared definitions for the pooling address generator and its max-pool
// consumer.
//   POOL_DATA_WIDTH : width of a signed feature word
//   pool_flags_t    : {valid, pack, last} bundle. It travels beside each
//                     SRAM read so that it lines up with the returned data.
//   smax(a, b)      : signed maximum. On a tie it returns a.
package pool_pkg;

  localparam int POOL_DATA_WIDTH = 16;

  typedef struct packed {
    logic valid;  // an address was issued in this slot
    logic pack;   // final element of a pooling window
    logic last;   // final element of the feature map
  } pool_flags_t;

  // Return b only when it is strictly greater. An equal value therefore
  // keeps the running accumulator (a).
  function automatic logic signed [POOL_DATA_WIDTH-1:0] smax(
    input logic signed [POOL_DATA_WIDTH-1:0] a,
    input logic signed [POOL_DATA_WIDTH-1:0] b
  );
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/pool_max_unit_if.sv
// Bus bundle between the pool_max_unit and its environment. The environment
// is made up of the address generator, the ifmap SRAM and the output buffer.
//   BIAS_VALID/BIAS/BIAS_PACK/BIAS_LAST : address stream from the generator
//   RD_EN/RD_ADDR/RD_DATA               : ifmap SRAM read port
//   OUT_VALID/OUT_DATA/OUT_ADDR/OUT_LAST: pooled result to the output buffer
//   ERR                                 : sticky protocol error
// Modports: master = environment side, slave = pool_max_unit side.
//
// Handshake: valid-only, with no ready in either direction. A beat transfers
// on every rising edge where its valid is high and the shared EN is high.
// Nothing can apply backpressure. EN is the single stall, and it is shared
// by the generator, the SRAM pipeline and this unit, so all of them freeze
// together.
interface pool_max_unit_if #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = pool_pkg::POOL_DATA_WIDTH,
  parameter int OUT_ADDR_WIDTH = 10
);

  logic                      BIAS_VALID;
  logic [ADDR_WIDTH-1:0]     BIAS;
  logic                      BIAS_PACK;
  logic                      BIAS_LAST;
  logic                      RD_EN;
  logic [ADDR_WIDTH-1:0]     RD_ADDR;
  logic [DATA_WIDTH-1:0]     RD_DATA;
  logic                      OUT_VALID;
  logic [DATA_WIDTH-1:0]     OUT_DATA;
  logic [OUT_ADDR_WIDTH-1:0] OUT_ADDR;
  logic                      OUT_LAST;
  logic                      ERR;

  modport master (
    output BIAS_VALID, BIAS, BIAS_PACK, BIAS_LAST, RD_DATA,
    input  RD_EN, RD_ADDR, OUT_VALID, OUT_DATA, OUT_ADDR, OUT_LAST, ERR
  );

  modport slave (
    input  BIAS_VALID, BIAS, BIAS_PACK, BIAS_LAST, RD_DATA,
    output RD_EN, RD_ADDR, OUT_VALID, OUT_DATA, OUT_ADDR, OUT_LAST, ERR
  );

endinterface

// File: rtl/pool_flag_delay.sv
// DEPTH-stage shift register for the {valid, pack, last} flag bundle.
// It delays the flags by the SRAM read latency, so that they arrive together
// with the data they describe. It advances only when en is high and is
// cleared by a synchronous reset.
//   clk, rst, en : clock, synchronous active-high reset, advance enable
//   d            : flags issued together with the read strobe
//   q            : flags aligned with the returned read data
module pool_flag_delay
  import pool_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  pool_flags_t d,
  output pool_flags_t q
);

  pool_flags_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/pool_max_unit.sv
// Max-pool consumer that sits directly behind the pooling address generator.
// It turns each incoming address into an ifmap SRAM read. When the data comes
// back, it folds the data into a signed running maximum per window. At every
// window close it emits one pooled word, together with a sequential output
// address and a map-last flag.
//   CLK, RESET, EN : clock, synchronous active-high reset, global advance
//   bus (slave)    : address stream in, SRAM read port, pooled result out, ERR
// Configuration macro: POOL_RELU_EN. When it is defined, each pooled result
// is clamped to max(value, 0) on output only. The accumulator is not clamped.
// RD_LAT must be within 1..4. DATA_WIDTH must equal pool_pkg::POOL_DATA_WIDTH,
// because smax works at that width.
module pool_max_unit
  import pool_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = POOL_DATA_WIDTH,
  parameter int OUT_ADDR_WIDTH = 10,
  parameter int RD_LAT         = 1
) (
  input logic          CLK,
  input logic          RESET,
  input logic          EN,
  pool_max_unit_if.slave bus
);

  // Stage A: issue the read, and capture the flags beside it.
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  pool_flags_t           flags_a;
  pool_flags_t           flags_b;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      flags_a   <= '0;
    end else if (EN) begin
      rd_en_q       <= bus.BIAS_VALID;
      rd_addr_q     <= bus.BIAS;
      flags_a.valid <= bus.BIAS_VALID;
      flags_a.pack  <= bus.BIAS_VALID & bus.BIAS_PACK;
      flags_a.last  <= bus.BIAS_VALID & bus.BIAS_LAST;
    end
  end

  // The strobe is gated by EN. During a stall the SRAM sees no read, even
  // though the registered strobe still holds the pending request.
  assign bus.RD_EN   = rd_en_q & EN;
  assign bus.RD_ADDR = rd_addr_q;

  pool_flag_delay #(.DEPTH(RD_LAT)) u_flag_delay (
    .clk (CLK),
    .rst (RESET),
    .en  (EN),
    .d   (flags_a),
    .q   (flags_b)
  );

  // Stage B: reduce the aligned data.
  logic signed [DATA_WIDTH-1:0] rd_word;
  logic signed [DATA_WIDTH-1:0] acc;
  logic signed [DATA_WIDTH-1:0] cur;
  logic signed [DATA_WIDTH-1:0] out_val;
  logic                         window_open;
  logic                         close;
  logic [OUT_ADDR_WIDTH-1:0]    out_cnt;
  logic                         out_valid_q;
  logic [DATA_WIDTH-1:0]        out_data_q;
  logic [OUT_ADDR_WIDTH-1:0]    out_addr_q;
  logic                         out_last_q;
  logic                         err_q;

  assign rd_word = bus.RD_DATA;

  always_comb begin
    cur     = window_open ? smax(acc, rd_word) : rd_word;
`ifdef POOL_RELU_EN
    out_val = cur[DATA_WIDTH-1] ? '0 : cur;
`else
    out_val = cur;
`endif
    // A map-last without pack still has to close the window, so the data
    // is not lost.
    close   = flags_b.pack | flags_b.last;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc         <= '0;
      window_open <= 1'b0;
      out_cnt     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else if (EN) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      if (flags_b.valid) begin
        if (!close) begin
          acc         <= cur;
          window_open <= 1'b1;
        end else begin
          out_valid_q <= 1'b1;
          out_data_q  <= out_val;
          out_addr_q  <= out_cnt;
          window_open <= 1'b0;
          if (flags_b.last) begin
            out_last_q <= 1'b1;
            out_cnt    <= '0;
            if (!flags_b.pack) err_q <= 1'b1;
          end else begin
            out_cnt <= out_cnt + 1'b1;
            // The map has more windows than the output buffer can address.
            if (out_cnt == {OUT_ADDR_WIDTH{1'b1}}) err_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.OUT_VALID = out_valid_q;
  assign bus.OUT_DATA  = out_data_q;
  assign bus.OUT_ADDR  = out_addr_q;
  assign bus.OUT_LAST  = out_last_q;
  assign bus.ERR       = err_q;

endmodule

// File: tb/tb_pool_max_unit.sv
// Testbench for pool_max_unit. It runs three DUTs side by side, at RD_LAT 1,
// 2 and 4, all fed by one address stream. Each DUT has its own EN-stalled
// SRAM model. A window-level reference model pushes the expected
// {last, addr, data} results into exp_q. The results observed from each DUT
// are compared against exp_q after every directed step.
// Honours POOL_RELU_EN in the same way as the RTL.
module tb_pool_max_unit;
  import pool_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int OW = 10;
  localparam int NI = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // shared stimulus
  logic          bias_valid;
  logic [AW-1:0] bias;
  logic          bias_pack;
  logic          bias_last;
  logic [DW-1:0] mem [4096];

  // per-instance observation
  logic          rd_en_o     [NI];
  logic          out_valid_o [NI];
  logic [DW-1:0] out_data_o  [NI];
  logic [OW-1:0] out_addr_o  [NI];
  logic          out_last_o  [NI];
  logic          err_o       [NI];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 4;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    pool_max_unit_if bus ();
    logic [DW-1:0] pipe [4];

    // The SRAM read pipeline freezes on EN, just like the rest of the datapath.
    always @(posedge clk) begin
      if (en) begin
        pipe[0] <= mem[bus.RD_ADDR];
        for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
      end
    end

    assign bus.BIAS_VALID = bias_valid;
    assign bus.BIAS       = bias;
    assign bus.BIAS_PACK  = bias_pack;
    assign bus.BIAS_LAST  = bias_last;
    assign bus.RD_DATA    = pipe[L-1];
    assign rd_en_o[g]     = bus.RD_EN;
    assign out_valid_o[g] = bus.OUT_VALID;
    assign out_data_o[g]  = bus.OUT_DATA;
    assign out_addr_o[g]  = bus.OUT_ADDR;
    assign out_last_o[g]  = bus.OUT_LAST;
    assign err_o[g]       = bus.ERR;

    pool_max_unit #(.RD_LAT(L)) dut (
      .CLK   (clk),
      .RESET (rst),
      .EN    (en),
      .bus   (bus)
    );
  end

  // scoreboard
  logic [OW+DW:0] exp_q [$];
  logic [OW+DW:0] obs_q [NI][$];
  int             obs_cyc [NI][$];
  int             n_tests = 0;
  int             n_fail  = 0;

  // Downstream consumes a result only on an EN cycle.
  always @(negedge clk) begin
    if (!rst && en) begin
      for (int i = 0; i < NI; i++) begin
        if (out_valid_o[i]) begin
          obs_q[i].push_back({out_last_o[i], out_addr_o[i], out_data_o[i]});
          obs_cyc[i].push_back(cyc);
        end
      end
    end
  end

  // reference model: whole windows, collected as a list
  logic signed [DW-1:0] win_q [$];
  int                   m_cnt;
  logic                 m_err;
  int                   addr_ptr = 0;

  task automatic model_word(input int d, input logic p, input logic l);
    logic signed [DW-1:0] mx;
    win_q.push_back(16'(d));
    if (p || l) begin
      mx = win_q[0];
      foreach (win_q[k]) if (win_q[k] > mx) mx = win_q[k];
`ifdef POOL_RELU_EN
      if (mx < 0) mx = '0;
`endif
      exp_q.push_back({l, 10'(m_cnt), mx});
      if (l) begin
        if (!p) m_err = 1'b1;
        m_cnt = 0;
      end else begin
        if (m_cnt == (1 << OW) - 1) m_err = 1'b1;
        m_cnt = (m_cnt + 1) % (1 << OW);
      end
      win_q.delete();
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    assert (got === expv)
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b1; en = 1'b1;
    bias_valid = 1'b0; bias_pack = 1'b0; bias_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    win_q.delete(); exp_q.delete();
    m_cnt = 0; m_err = 1'b0;
  endtask

  // Presents one address for exactly one EN cycle. Returns the edge count
  // of the edge that accepted the address.
  task automatic drive_word(input int d, input logic p, input logic l, output int e);
    mem[addr_ptr] = d[DW-1:0];
    en = 1'b1; bias_valid = 1'b1; bias = AW'(addr_ptr);
    bias_pack = p; bias_last = l;
    @(posedge clk); #1;
    e = cyc;
    bias_valid = 1'b0; bias_pack = 1'b0; bias_last = 1'b0;
    addr_ptr = (addr_ptr + 1) % 4096;
    model_word(d, p, l);
  endtask

  // Drops EN for n cycles while presenting junk on the address inputs.
  // RD_EN has to stay 0 for the whole stall.
  task automatic stall(input int n);
    en = 1'b0; bias_valid = 1'b1; bias = AW'($urandom);
    bias_pack = 1'($urandom); bias_last = 1'($urandom);
    for (int c = 0; c < n; c++) begin
      #2;
      for (int i = 0; i < NI; i++)
        check($sformatf("stall rd_en L%0d c%0d", lat_of(i), c), 32'(rd_en_o[i]), 32'd0);
      @(posedge clk); #1;
    end
    en = 1'b1; bias_valid = 1'b0; bias_pack = 1'b0; bias_last = 1'b0;
  endtask

  task automatic drain();
    en = 1'b1; bias_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic check_results(input string name);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s L%0d count", name, lat_of(i)), 32'(obs_q[i].size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < obs_q[i].size(); k++)
        check($sformatf("%s L%0d {last,addr,data}#%0d", name, lat_of(i), k),
              32'(obs_q[i][k]), 32'(exp_q[k]));
      check($sformatf("%s L%0d err", name, lat_of(i)), 32'(err_o[i]), 32'(m_err));
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < NI; i++) begin
      obs_q[i].delete();
      obs_cyc[i].delete();
    end
    exp_q.delete();
  endtask

  initial begin
    int e;
    int nwin;
    int wsz;
    for (int a = 0; a < 4096; a++) mem[a] = '0;
    bias = '0;

    // reset state
    do_reset();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset rd_en L%0d", lat_of(i)), 32'(rd_en_o[i]), 32'd0);
      check($sformatf("reset out_valid L%0d", lat_of(i)), 32'(out_valid_o[i]), 32'd0);
      check($sformatf("reset out_data L%0d", lat_of(i)), 32'(out_data_o[i]), 32'd0);
      check($sformatf("reset out_addr L%0d", lat_of(i)), 32'(out_addr_o[i]), 32'd0);
      check($sformatf("reset out_last L%0d", lat_of(i)), 32'(out_last_o[i]), 32'd0);
      check($sformatf("reset err L%0d", lat_of(i)), 32'(err_o[i]), 32'd0);
    end

    // basic 2x2 max with latency
    drive_word(3, 1'b0, 1'b0, e);
    drive_word(-5, 1'b0, 1'b0, e);
    drive_word(7, 1'b0, 1'b0, e);
    drive_word(1, 1'b1, 1'b1, e);
    drain();
    check_results("basic");
    for (int i = 0; i < NI; i++)
      if (obs_cyc[i].size() > 0)
        check($sformatf("basic latency L%0d", lat_of(i)), 32'(obs_cyc[i][0]), 32'(e + lat_of(i) + 1));
    clear_obs();

    // all-negative window
    drive_word(-9, 1'b0, 1'b0, e);
    drive_word(-2, 1'b0, 1'b0, e);
    drive_word(-4, 1'b0, 1'b0, e);
    drive_word(-3, 1'b1, 1'b1, e);
    drain();
    check_results("allneg");
    clear_obs();

    // back-to-back 4x4 map in 2x2 windows, then a one-word map that must
    // land at address 0
    for (int k = 0; k < 16; k++)
      drive_word(int'($urandom_range(0, 65535)) - 32768, 1'(k % 4 == 3), 1'(k == 15), e);
    drive_word(int'($urandom_range(0, 65535)) - 32768, 1'b1, 1'b1, e);
    drain();
    check_results("b2b");
    clear_obs();

    // EN stall in the middle of a window
    for (int k = 0; k < 8; k++) begin
      drive_word(int'($urandom_range(0, 2000)) - 1000, 1'(k % 4 == 3), 1'(k == 7), e);
      if (k == 1) stall(3);
    end
    drain();
    check_results("stall");
    clear_obs();

    // last without pack: the window is flushed and ERR sticks
    drive_word(10, 1'b0, 1'b0, e);
    drive_word(25, 1'b0, 1'b1, e);
    drive_word(-7, 1'b0, 1'b0, e);
    drive_word(4, 1'b1, 1'b0, e);
    drain();
    check_results("lastnopack");
    clear_obs();
    drain();
    check_results("err sticky");
    do_reset();
    for (int i = 0; i < NI; i++)
      check($sformatf("err cleared L%0d", lat_of(i)), 32'(err_o[i]), 32'd0);
    clear_obs();

    // reset mid-window, then a map of 1x1 windows
    drive_word(500, 1'b0, 1'b0, e);
    drive_word(600, 1'b0, 1'b0, e);
    do_reset();
    for (int k = 0; k < 4; k++)
      drive_word(int'($urandom_range(0, 65535)) - 32768, 1'b1, 1'(k == 3), e);
    drain();
    check_results("rst+1x1");
    clear_obs();

    // random maps with random window sizes and random stalls
    for (int m = 0; m < 3; m++) begin
      nwin = $urandom_range(2, 6);
      for (int w = 0; w < nwin; w++) begin
        wsz = $urandom_range(1, 4);
        for (int k = 0; k < wsz; k++) begin
          if ($urandom_range(0, 3) == 0) stall($urandom_range(1, 3));
          drive_word(int'($urandom_range(0, 65535)) - 32768, 1'(k == wsz - 1),
                     1'(k == wsz - 1 && w == nwin - 1), e);
        end
      end
    end
    drain();
    check_results("random");
    clear_obs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
